mips_register_file: RTL and testbench

//  MIPS register file: 32 x 32-bit GPRs plus the HI/LO pair. It is the consumer end of the

---
 rtl/mips_pkg.sv | 18 +
 rtl/mips_hilo_reg.sv | 44 ++++
 rtl/mips_register_file.sv | 73 +++++++
 tb/tb_mips_register_file.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants: register file geometry, GPR names
// and the HI/LO write-select encodings.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;
   localparam reg_idx_t REG_V0   = 5'd2;

   localparam logic [1:0] HILO_HI   = 2'b01;
   localparam logic [1:0] HILO_LO   = 2'b10;
   localparam logic [1:0] HILO_BOTH = 2'b11;

endpackage

// File: rtl/mips_hilo_reg.sv
// HI/LO multiply/divide result pair. Each half has its own enable taken from
// HiLoSel, and both are gated by HiLoWrite. Neither half is forwarded.
module mips_hilo_reg #(
   parameter int DATA_W = mips_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              Reset_n,
   input  logic              HiLoWrite,
   input  logic [1:0]        HiLoSel,
   input  logic [DATA_W-1:0] HiIn,
   input  logic [DATA_W-1:0] LoIn,
   output logic [DATA_W-1:0] Hi,
   output logic [DATA_W-1:0] Lo
);
   import mips_pkg::*;

   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   // NOTE: hold values are assigned first so no path leaves hi_d/lo_d unassigned (no latch).
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (HiLoWrite) begin
         if ((HiLoSel & HILO_HI) != 2'b00) hi_d = HiIn;
         if ((HiLoSel & HILO_LO) != 2'b00) lo_d = LoIn;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!Reset_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign Hi = hi_q;
   assign Lo = lo_q;

endmodule

// File: rtl/mips_register_file.sv
// MIPS 32-entry GPR file with two combinational read ports, optional
// write-to-read forwarding, a $v0 debug tap and the HI/LO pair.
module mips_register_file #(
   parameter int DATA_W    = mips_pkg::DATA_W,
   parameter int ADDR_W    = mips_pkg::ADDR_W,
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic              clk,
   input  logic              Reset_n,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              HiLoWrite,
   input  logic [1:0]        HiLoSel,
   input  logic [DATA_W-1:0] HiIn,
   input  logic [DATA_W-1:0] LoIn,
   output logic [DATA_W-1:0] Hi,
   output logic [DATA_W-1:0] Lo,
   output logic [DATA_W-1:0] RegisterV0
);
   import mips_pkg::*;

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);
   localparam logic [ADDR_W-1:0] IDX_V0   = ADDR_W'(REG_V0);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic              wr_en;

   // Reset_n is folded in so an unknown RegWrite during reset neither writes nor forwards.
   assign wr_en = Reset_n && RegWrite && (WriteReg != IDX_ZERO);

   // NOTE: the whole array is cleared on reset because software may read any GPR before writing it.
   always_ff @(posedge clk) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[WriteReg] <= WriteData;
      end
   end

   always_comb begin
      ReadData1 = regs_q[ReadReg1];
      if (ReadReg1 == IDX_ZERO)                           ReadData1 = '0;
      else if (BYPASS_EN && wr_en && WriteReg == ReadReg1) ReadData1 = WriteData;
   end

   always_comb begin
      ReadData2 = regs_q[ReadReg2];
      if (ReadReg2 == IDX_ZERO)                           ReadData2 = '0;
      else if (BYPASS_EN && wr_en && WriteReg == ReadReg2) ReadData2 = WriteData;
   end

   assign RegisterV0 = regs_q[IDX_V0];

   mips_hilo_reg #(
      .DATA_W (DATA_W)
   ) u_hilo (
      .clk       (clk),
      .Reset_n   (Reset_n),
      .HiLoWrite (HiLoWrite),
      .HiLoSel   (HiLoSel),
      .HiIn      (HiIn),
      .LoIn      (LoIn),
      .Hi        (Hi),
      .Lo        (Lo)
   );

endmodule

// File: tb/tb_mips_register_file.sv
// Bench for mips_register_file: a forwarding and a non-forwarding instance share
// stimulus; an array model is compared every cycle, plus directed literal checks.
module tb_mips_register_file;
   import mips_pkg::*;

   logic     clk = 1'b0;
   logic     Reset_n;
   reg_idx_t ReadReg1, ReadReg2, WriteReg;
   logic     RegWrite, HiLoWrite;
   logic [1:0] HiLoSel;
   word_t    WriteData, HiIn, LoIn;
   word_t    rd1, rd2, hi, lo, v0;
   word_t    nb_rd1, nb_rd2, nb_hi, nb_lo, nb_v0;

   always #5 clk = ~clk;

   mips_register_file #(.BYPASS_EN(1'b1)) dut (
      .clk(clk), .Reset_n(Reset_n),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1), .ReadData2(rd2),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .HiLoWrite(HiLoWrite), .HiLoSel(HiLoSel), .HiIn(HiIn), .LoIn(LoIn),
      .Hi(hi), .Lo(lo), .RegisterV0(v0)
   );

   mips_register_file #(.BYPASS_EN(1'b0)) dut_nb (
      .clk(clk), .Reset_n(Reset_n),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(nb_rd1), .ReadData2(nb_rd2),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .HiLoWrite(HiLoWrite), .HiLoSel(HiLoSel), .HiIn(HiIn), .LoIn(LoIn),
      .Hi(nb_hi), .Lo(nb_lo), .RegisterV0(nb_v0)
   );

   // Reference state: architectural contents as the spec rules define them.
   word_t model [32];
   word_t hi_m, lo_m;
   logic  chk_en = 1'b0;
   int    n_checks = 0;
   int    n_pass   = 0;

   always @(posedge clk) begin
      if (!Reset_n) begin
         for (int i = 0; i < 32; i++) model[i] <= '0;
         hi_m <= '0;
         lo_m <= '0;
      end else begin
         if (RegWrite && WriteReg != 5'd0) model[WriteReg] <= WriteData;
         if (HiLoWrite && HiLoSel[0]) hi_m <= HiIn;
         if (HiLoWrite && HiLoSel[1]) lo_m <= LoIn;
      end
   end

   task automatic check(input string name, input word_t act, input word_t exp);
      n_checks = n_checks + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic word_t exp_read(input reg_idx_t idx, input bit forward);
      if (idx == 5'd0) return '0;
      if (forward && RegWrite && WriteReg != 5'd0 && WriteReg == idx) return WriteData;
      return model[idx];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         if (Reset_n) begin
            check("cmp_rd1",    rd1,    exp_read(ReadReg1, 1'b1));
            check("cmp_rd2",    rd2,    exp_read(ReadReg2, 1'b1));
            check("cmp_nb_rd1", nb_rd1, exp_read(ReadReg1, 1'b0));
            check("cmp_nb_rd2", nb_rd2, exp_read(ReadReg2, 1'b0));
         end
         check("cmp_hi",    hi,    hi_m);
         check("cmp_lo",    lo,    lo_m);
         check("cmp_v0",    v0,    model[2]);
         check("cmp_nb_hi", nb_hi, hi_m);
         check("cmp_nb_lo", nb_lo, lo_m);
         check("cmp_nb_v0", nb_v0, model[2]);
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic rand_cycle();
      next();
      Reset_n   = 1'b1;
      RegWrite  = ($urandom_range(0, 3) != 0);
      WriteReg  = ($urandom_range(0, 1) != 0) ? reg_idx_t'($urandom_range(0, 7))
                                              : reg_idx_t'($urandom_range(0, 31));
      WriteData = $urandom;
      ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg : reg_idx_t'($urandom_range(0, 31));
      ReadReg2  = ($urandom_range(0, 3) == 0) ? WriteReg : reg_idx_t'($urandom_range(0, 7));
      HiLoWrite = ($urandom_range(0, 2) == 0);
      HiLoSel   = 2'($urandom_range(0, 3));
      HiIn      = $urandom;
      LoIn      = $urandom;
   endtask

   initial begin
      // Reset held two clocks with a write pending that must be ignored.
      Reset_n = 1'b0; RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
      ReadReg1 = 5'd5; ReadReg2 = 5'd0;
      HiLoWrite = 1'b0; HiLoSel = 2'b00; HiIn = '0; LoIn = '0;
      next(); next();
      Reset_n = 1'b1; RegWrite = 1'b0; chk_en = 1'b1;
      mid();
      check("rst_rd1", rd1, 32'h0);
      check("rst_hi",  hi,  32'h0);
      check("rst_lo",  lo,  32'h0);
      check("rst_v0",  v0,  32'h0);

      // Write then read on both ports.
      next(); RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h12345678;
      next(); RegWrite = 1'b0; ReadReg1 = 5'd7; ReadReg2 = 5'd7;
      mid();
      check("wr_rd1", rd1, 32'h12345678);
      check("wr_rd2", rd2, 32'h12345678);

      // $zero is neither written nor forwarded.
      next(); RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF; ReadReg1 = 5'd0;
      mid();
      check("zero_during", rd1, 32'h0);
      next(); RegWrite = 1'b0;
      mid();
      check("zero_after", rd1, 32'h0);

      // Forwarding versus old value on the non-forwarding instance.
      next(); RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h11112222;
      next(); WriteData = 32'hA5A5A5A5; ReadReg2 = 5'd9;
      mid();
      check("byp_rd2",    rd2,    32'hA5A5A5A5);
      check("nobyp_rd2",  nb_rd2, 32'h11112222);
      next(); RegWrite = 1'b0;
      mid();
      check("byp_after",   rd2,    32'hA5A5A5A5);
      check("nobyp_after", nb_rd2, 32'hA5A5A5A5);

      // $v0 tap has register latency, no forwarding.
      next(); RegWrite = 1'b1; WriteReg = 5'd2; WriteData = 32'hCAFEF00D;
      mid();
      check("v0_during", v0, 32'h0);
      next(); RegWrite = 1'b0;
      mid();
      check("v0_after", v0, 32'hCAFEF00D);

      // HI/LO: both, then LO only, then a select-none no-op.
      next(); HiLoWrite = 1'b1; HiLoSel = 2'b11; HiIn = 32'h1; LoIn = 32'h2;
      mid();
      check("hilo_no_fwd_hi", hi, 32'h0);
      check("hilo_no_fwd_lo", lo, 32'h0);
      next(); HiLoSel = 2'b10; HiIn = 32'hFF; LoIn = 32'h3;
      mid();
      check("hilo_both_hi", hi, 32'h1);
      check("hilo_both_lo", lo, 32'h2);
      next(); HiLoSel = 2'b00; HiIn = 32'h9; LoIn = 32'h9;
      mid();
      check("hilo_lo_hi", hi, 32'h1);
      check("hilo_lo_lo", lo, 32'h3);
      next(); HiLoWrite = 1'b0;
      mid();
      check("hilo_nop_hi", hi, 32'h1);
      check("hilo_nop_lo", lo, 32'h3);

      // Random traffic, a mid-sequence reset with writes pending, a sweep of zeros, more traffic.
      for (int c = 0; c < 100; c++) rand_cycle();
      next();
      Reset_n = 1'b0; RegWrite = 1'b1; WriteReg = 5'd3; WriteData = $urandom;
      HiLoWrite = 1'b1; HiLoSel = 2'b11; HiIn = $urandom; LoIn = $urandom;
      next();
      Reset_n = 1'b1; RegWrite = 1'b0; HiLoWrite = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ReadReg1 = reg_idx_t'(i);
         ReadReg2 = reg_idx_t'(i + 16);
         mid();
         check($sformatf("sweep_r%0d", i),      rd1, 32'h0);
         check($sformatf("sweep_r%0d", i + 16), rd2, 32'h0);
         next();
      end
      check("sweep_hi", hi, 32'h0);
      check("sweep_lo", lo, 32'h0);
      check("sweep_v0", v0, 32'h0);
      for (int c = 0; c < 100; c++) rand_cycle();

      next();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
